// File: rtl/mem_pkg.sv
// Shared types and helpers for the parity-protected 9-bit memory path.
package mem_pkg;

    localparam int MEM_W   = 9;
    localparam int DATA_W  = 8;
    localparam int PAR_BIT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Even parity: the stored parity bit equals the XOR of the data bits.
    function automatic logic par_ok(input logic [MEM_W-1:0] word);
        return word[PAR_BIT] == (^word[DATA_W-1:0]);
    endfunction

endpackage

// File: rtl/mem_parity_chk.sv
// Combinational parity checker for one 9-bit memory word.
// Kept standalone so the write-side parity generator can share it.
module mem_parity_chk
    import mem_pkg::*;
(
    input  logic [MEM_W-1:0] word,
    output logic             err
);

    assign err = !par_ok(word);

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read controller: one single-cycle read per word, parity check on
// return, and delivery of each word on a valid/ready stream.
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_data, out_addr and out_par_err do not change.
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [MEM_W-1:0]  mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_par_err,
    output logic              busy,
    output logic              done,
    input  logic              clr_err,
    output logic [ERR_W-1:0]  err_count
);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              word_err;
    logic              accept;
    logic              err_inc;

    mem_parity_chk u_parity_chk (
        .word (mem_data),
        .err  (word_err)
    );

    assign busy    = (state != IDLE);
    assign accept  = out_valid && out_ready;
    assign err_inc = (state == WAIT) && word_err;

    // Burst FSM with address/length counters and the registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_par_err <= 1'b0;
            done        <= 1'b0;
        end else begin
            done     <= 1'b0;
            mem_read <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            cur_addr    <= start_addr;
                            remaining   <= burst_len;
                            mem_address <= start_addr;
                            mem_read    <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    out_data    <= mem_data[DATA_W-1:0];
                    out_addr    <= cur_addr;
                    out_par_err <= word_err;
                    out_valid   <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // Address wraps naturally at the top of the space.
                            cur_addr    <= cur_addr + 1'b1;
                            mem_address <= cur_addr + 1'b1;
                            mem_read    <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating parity-error counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (err_inc && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed self-checking bench for mem_burst_reader.
module tb_mem_burst_reader;

    localparam int ADDR_W = 16;
    localparam int LEN_W  = 8;
    localparam int ERR_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [8:0]        mem_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_par_err;
    logic              busy;
    logic              done;
    logic              clr_err;
    logic [ERR_W-1:0]  err_count;

    logic [8:0]  mem [0:65535];
    logic [24:0] exp_q[$];
    logic [24:0] exp_word;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int hs_cyc = 0;
    int done_cnt = 0;
    int mem_read_cnt = 0;
    int busy_hi_cnt = 0;
    bit zero_len = 1'b0;
    bit done_prev = 1'b0;

    mem_burst_reader #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .ERR_W  (ERR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .burst_len   (burst_len),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_par_err (out_par_err),
        .busy        (busy),
        .done        (done),
        .clr_err     (clr_err),
        .err_count   (err_count)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: samples the read strobe at the end of ISSUE, data valid in WAIT.
    initial mem_data = '0;
    always @(posedge clk) begin
        if (mem_read) mem_data <= mem[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk(input logic [7:0] d);
        return {^d, d};
    endfunction

    function automatic logic [24:0] ew(input logic [15:0] a, input logic e, input logic [7:0] d);
        return {a, e, d};
    endfunction

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_read) mem_read_cnt++;
        if (busy) busy_hi_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_word = exp_q.pop_front();
                check("word", {7'b0, out_addr, out_par_err, out_data}, {7'b0, exp_word});
            end
            hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", 32'(busy), 32'd0);
            check("done_one_cycle", 32'(done_prev), 32'd0);
            if (!zero_len) check("done_after_hs", 32'(cyc - hs_cyc), 32'd1);
        end
        done_prev = done;
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [15:0] a, input logic [7:0] l);
        @(posedge clk);
        #1;
        start_addr = a;
        burst_len  = l;
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("valid_seen", 32'(found), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(found), 32'd1);
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed test sequence.
    initial begin
        int d0;
        int rm;
        int n;
        bit found;

        for (int i = 0; i < 65536; i++) mem[i] = '0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0;
        out_ready = 1'b0; clr_err = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);

        // Clean 4-word burst.
        mem[16'h0010] = mk(8'hA5); mem[16'h0011] = mk(8'h3C);
        mem[16'h0012] = mk(8'h7E); mem[16'h0013] = mk(8'h01);
        exp_q.push_back(ew(16'h0010, 1'b0, 8'hA5));
        exp_q.push_back(ew(16'h0011, 1'b0, 8'h3C));
        exp_q.push_back(ew(16'h0012, 1'b0, 8'h7E));
        exp_q.push_back(ew(16'h0013, 1'b0, 8'h01));
        out_ready = 1'b1;
        start_burst(16'h0010, 8'd4);
        wait_valid(10);
        check("first_valid_latency", 32'(cyc - start_cyc), 32'd3);
        wait_done(40);
        check("t1_err_count", 32'(err_count), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Same burst with a corrupted parity bit at 0x11.
        mem[16'h0011][8] = ~mem[16'h0011][8];
        exp_q.push_back(ew(16'h0010, 1'b0, 8'hA5));
        exp_q.push_back(ew(16'h0011, 1'b1, 8'h3C));
        exp_q.push_back(ew(16'h0012, 1'b0, 8'h7E));
        exp_q.push_back(ew(16'h0013, 1'b0, 8'h01));
        start_burst(16'h0010, 8'd4);
        wait_done(40);
        check("t2_err_count", 32'(err_count), 32'd1);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Address wrap at the top of the space.
        mem[16'hFFFE] = mk(8'h81); mem[16'hFFFF] = mk(8'h42); mem[16'h0000] = mk(8'hC3);
        exp_q.push_back(ew(16'hFFFE, 1'b0, 8'h81));
        exp_q.push_back(ew(16'hFFFF, 1'b0, 8'h42));
        exp_q.push_back(ew(16'h0000, 1'b0, 8'hC3));
        start_burst(16'hFFFE, 8'd3);
        wait_done(40);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t3_err_count", 32'(err_count), 32'd1);

        // Back-pressure: word held stable, no new read while stalled.
        mem[16'h0020] = mk(8'h5A); mem[16'h0021] = mk(8'h99);
        exp_q.push_back(ew(16'h0020, 1'b0, 8'h5A));
        exp_q.push_back(ew(16'h0021, 1'b0, 8'h99));
        out_ready = 1'b0;
        start_burst(16'h0020, 8'd2);
        wait_valid(10);
        rm = mem_read_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'h5A);
            check("hold_addr", 32'(out_addr), 32'h0020);
            check("hold_par_err", 32'(out_par_err), 32'd0);
            check("hold_mem_read", 32'(mem_read), 32'd0);
        end
        check("hold_no_read", 32'(mem_read_cnt - rm), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(20);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length burst.
        idle_cycles(1);
        zero_len = 1'b1;
        mem_read_cnt = 0;
        busy_hi_cnt = 0;
        d0 = done_cnt;
        start_burst(16'h0030, 8'd0);
        wait_done(5);
        idle_cycles(3);
        check("zl_done_count", 32'(done_cnt - d0), 32'd1);
        check("zl_busy_cycles", 32'(busy_hi_cnt), 32'd0);
        check("zl_mem_reads", 32'(mem_read_cnt), 32'd0);
        zero_len = 1'b0;

        // Start while busy is ignored.
        out_ready = 1'b0;
        mem_read_cnt = 0;
        exp_q.push_back(ew(16'h0010, 1'b0, 8'hA5));
        start_burst(16'h0010, 8'd1);
        wait_valid(10);
        @(posedge clk);
        #1;
        start_addr = 16'h0040; burst_len = 8'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        out_ready = 1'b1;
        wait_done(10);
        idle_cycles(10);
        check("busy_start_reads", 32'(mem_read_cnt), 32'd1);
        check("busy_start_idle", 32'(busy), 32'd0);
        check("busy_start_queue", 32'(exp_q.size()), 32'd0);

        // Clear coinciding with a parity error: clear wins.
        check("t6_err_pre", 32'(err_count), 32'd1);
        exp_q.push_back(ew(16'h0011, 1'b1, 8'h3C));
        start_burst(16'h0011, 8'd1);
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        check("clr_wins", 32'(err_count), 32'd0);
        wait_done(10);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during WAIT of the second word.
        idle_cycles(1);
        exp_q.push_back(ew(16'h0010, 1'b0, 8'hA5));
        exp_q.push_back(ew(16'h0011, 1'b1, 8'h3C));
        start_burst(16'h0010, 8'd4);
        n = 1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_read) n++;
            if (n == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("t7_second_read", 32'(found), 32'd1);
        @(posedge clk);
        #2;
        check("t7_busy_pre", 32'(busy), 32'd1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_mem_read", 32'(mem_read), 32'd0);
        check("arst_mem_address", 32'(mem_address), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_addr", 32'(out_addr), 32'd0);
        check("arst_out_par_err", 32'(out_par_err), 32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rm = mem_read_cnt;
        idle_cycles(8);
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);
        check("arst_idle_after", 32'(busy), 32'd0);
        check("arst_no_reads_after", 32'(mem_read_cnt - rm), 32'd0);
        check("arst_valid_after", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Read-side controller for the parity-protected 9-bit memory (8 data bits plus a parity bit in bit 8). It accepts a burst command (start address, length), issues one single-cycle read per word, checks each returned word's parity, and delivers the 8-bit data on a valid/ready stream with a per-word error flag. It sits between the memory and any consumer that drains memory contents, such as a scrubber or a dump engine. It never writes the memory.

## Interface
- ADDR_W, default 16: memory address width.
- LEN_W, default 8: burst length width.
- ERR_W, default 16: error counter width.

- clk  in  1  Single clock, rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- start  in  1  Burst request; sampled only in IDLE.
- start_addr  in  ADDR_W  First address of the burst.
- burst_len  in  LEN_W  Number of words to read; 0 means no reads.
- mem_read  out  1  Read strobe to the memory, registered.
- mem_address  out  ADDR_W  Read address to the memory, registered.
- mem_data  in  9  Memory read data: {parity, data[7:0]}.
- out_valid  out  1  Output word valid.
- out_ready  in  1  Consumer accepts the word.
- out_data  out  8  Data bits [7:0] of the word.
- out_addr  out  ADDR_W  Address the word was read from.
- out_par_err  out  1  Set when mem_data[8] != ^mem_data[7:0].
- busy  out  1  High in any state other than IDLE.
- done  out  1  One-cycle pulse when the burst completes.
- clr_err  in  1  Synchronous clear of err_count.
- err_count  out  ERR_W  Saturating count of parity errors.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: on start with burst_len != 0, latch cur_addr=start_addr and remaining=burst_len, then go to ISSUE. On start with burst_len == 0, pulse done the next cycle and stay in IDLE. start is ignored outside IDLE.
- ISSUE (1 cycle): mem_read=1, mem_address=cur_addr. Next state is WAIT.
- WAIT (1 cycle): mem_data is valid. At the end of the cycle, capture out_data=mem_data[7:0], out_addr=cur_addr and out_par_err. Increment err_count on error. Next state is HOLD.
- HOLD: out_valid=1, and out_data, out_addr and out_par_err are held stable until out_ready. On the handshake, remaining is decremented. If the decremented value is 0, pulse done and go to IDLE. Otherwise cur_addr increments and the FSM goes to ISSUE.
- Address increment wraps modulo 2^ADDR_W, so 16'hFFFF is followed by 16'h0000.
- Parity is even: the stored bit 8 equals the XOR of the data bits.
- err_count saturates at all-ones. If clr_err and an increment occur in the same cycle, clear wins and the result is 0.
- mem_read is 0 outside ISSUE. mem_address holds its last value.

## Timing
- Reset values: all outputs are 0, the state is IDLE, and err_count is 0.
- An asserted reset during a burst aborts it immediately. No done pulse is generated and out_valid drops at once.
- start is accepted at edge E0. ISSUE occupies cycle E0..E1, WAIT occupies E1..E2, and out_valid rises after E2. This gives a latency of 3 cycles from start to the first out_valid.
- Maximum throughput is one word per 3 cycles when out_ready is held high.
- done asserts in the cycle after the last handshake, for exactly 1 cycle, and busy falls in the same cycle.
- Memory contract: the memory samples mem_read at the rising edge that ends ISSUE, and mem_data is valid throughout WAIT.

## Structure
- Package mem_pkg:
  - state enum: IDLE, ISSUE, WAIT, HOLD.
  - constants: MEM_W=9, DATA_W=8, PAR_BIT=8.
  - function par_ok(word).
- Sub-module mem_parity_chk: combinational, 9-bit input, err output. It is shared with a future write-side parity generator.
- Top level: FSM, address/remaining counters, output register and error counter.

## Test plan
- Preload 0x10..0x13 with correct parity, then start_addr=0x10, burst_len=4 with out_ready=1. Expect 4 words in address order, out_par_err=0, done one cycle after the 4th handshake, err_count=0.
- Corrupt bit 8 at 0x11 and run the same burst. Expect out_par_err=1 only on the word with out_addr=0x11, and err_count=1.
- Run start_addr=0xFFFE, burst_len=3. Expect addresses 0xFFFE, 0xFFFF, 0x0000.
- Hold out_ready=0 for 5 cycles in HOLD. Expect out_data, out_addr and out_par_err stable, mem_read=0, and no new read issued.
- Start with burst_len=0. Expect done pulse, busy never 1, mem_read never 1. Also assert start while busy and check it is ignored.
- Pull rst_n low during WAIT of word 2. Expect outputs to go to 0 asynchronously, no done pulse, and IDLE after release. Separately, assert clr_err together with an error event and expect err_count=0.
